// File: rtl/mem_burst_master.sv
// mem_burst_master: turns one burst command into per-word
// valid/ready beats on a single-port memory.
module mem_burst_master #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic                  mem_w_r_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   L_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   L_ZERO = 0;
  localparam logic [1:0]            TWO = 2'd2;

  state_t                state;
  logic                  live;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   rem;
  logic                  inflight;
  logic [1:0]            cnt;
  logic                  wp;
  logic                  rp;
  logic [WIDTH-1:0]      fifo [2];

  logic       cmd_fire;
  logic       wr_beat;
  logic       rd_beat;
  logic       pop;
  logic [1:0] occ;

  // words issued but not yet handed downstream
  assign occ = cnt + {1'b0, inflight};

  assign cmd_ready_o = (state == IDLE) & live;
  assign cmd_fire = cmd_valid_i & cmd_ready_o;
  assign wr_beat = (state == WR) & mem_valid_o & mem_ready_i;
  assign rd_beat = (state == RD) & mem_valid_o & mem_ready_i;
  assign rd_valid_o = cnt != 2'd0;
  assign rd_data_o = fifo[rp];
  assign pop = rd_valid_o & rd_ready_i;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;

  always_comb begin
    mem_valid_o = 1'b0;
    mem_w_r_o = 1'b0;
    mem_addr_o = addr;
    mem_wdata_o = '0;
    wr_ready_o = 1'b0;
    unique case (state)
      IDLE: mem_addr_o = '0;
      WR: begin
        mem_valid_o = wr_valid_i;
        mem_w_r_o = 1'b1;
        mem_wdata_o = wr_data_i;
        wr_ready_o = mem_ready_i;
      end
      RD: mem_valid_o = (rem != L_ZERO) & (occ < TWO);
      DONE: mem_valid_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      live <= 1'b0;
      addr <= '0;
      rem <= '0;
      inflight <= 1'b0;
      cnt <= 2'd0;
      wp <= 1'b0;
      rp <= 1'b0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else begin
      live <= 1'b1;
      // read data lands one edge after its beat
      if (inflight) begin
        fifo[wp] <= mem_rdata_i;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= occ - {1'b0, pop};
      inflight <= rd_beat;
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            addr <= cmd_addr_i;
            rem <= cmd_len_i;
            if (cmd_len_i == L_ZERO) state <= DONE;
            else if (cmd_wr_i) state <= WR;
            else state <= RD;
          end
        end
        WR: begin
          if (wr_beat) begin
            addr <= addr + A_ONE;
            rem <= rem - L_ONE;
            if (rem == L_ONE) state <= DONE;
          end
        end
        RD: begin
          if (rd_beat) begin
            addr <= addr + A_ONE;
            rem <= rem - L_ONE;
          end
          if (rem == L_ZERO && cnt == 2'd0 && !inflight)
            state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: random bursts against a word-level
// memory/stream reference model.
module tb_mem_burst_master;

  localparam int DEPTH = 16;
  localparam int WIDTH = 16;
  localparam int AW = 4;
  localparam int CAP = 400;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             cmd_wr_i;
  logic [AW-1:0]    cmd_addr_i;
  logic [AW:0]      cmd_len_i;
  logic             wr_valid_i;
  logic             wr_ready_o;
  logic [WIDTH-1:0] wr_data_i;
  logic             rd_valid_o;
  logic             rd_ready_i;
  logic [WIDTH-1:0] rd_data_o;
  logic             mem_valid_o;
  logic             mem_ready_i;
  logic             mem_w_r_o;
  logic [AW-1:0]    mem_addr_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic [WIDTH-1:0] mem_rdata_i;
  logic             busy_o;
  logic             done_o;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];

  int checks = 0;
  int fails = 0;

  mem_burst_master #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_wr_i(cmd_wr_i), .cmd_addr_i(cmd_addr_i),
    .cmd_len_i(cmd_len_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_data_o(rd_data_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_w_r_o(mem_w_r_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // single-port memory: write on beat, read data next cycle
  always @(posedge clk) begin
    if (mem_valid_o && mem_ready_i) begin
      if (mem_w_r_o) mem[mem_addr_o] <= mem_wdata_o;
      else mem_rdata_i <= mem[mem_addr_o];
    end else begin
      mem_rdata_i <= WIDTH'($urandom);
    end
  end

  task automatic send_cmd(input bit wr, input int a, input int n);
    @(posedge clk); #1;
    cmd_valid_i = 1'b1;
    cmd_wr_i = wr;
    cmd_addr_i = AW'(a);
    cmd_len_i = (AW+1)'(n);
    @(negedge clk);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL cmd_ready: got %b want 1", cmd_ready_o);
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic run_write(input int a, input int n, input int mode);
    logic [WIDTH-1:0] d [$];
    int idx;
    int cyc;
    bit vld;
    bit mrdy;
    for (int i = 0; i < n; i++) d.push_back(WIDTH'($urandom));
    send_cmd(1'b1, a, n);
    idx = 0;
    cyc = 0;
    while (idx < n) begin
      vld = (mode == 0) || ($urandom_range(3) != 0);
      mrdy = (mode == 0) || ($urandom_range(3) != 0);
      wr_valid_i = vld;
      wr_data_i = d[idx];
      mem_ready_i = mrdy;
      @(negedge clk);
      checks++;
      if ({mem_valid_o, mem_w_r_o, wr_ready_o, busy_o, done_o,
           cmd_ready_o} !== {vld, 1'b1, mrdy, 1'b1, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL wr_ctrl: got v=%b w=%b rdy=%b busy=%b done=%b cr=%b want %b 1 %b 1 0 0",
                 mem_valid_o, mem_w_r_o, wr_ready_o, busy_o, done_o,
                 cmd_ready_o, vld, mrdy);
      end
      if (vld) begin
        checks++;
        if (mem_addr_o !== AW'(a + idx) || mem_wdata_o !== d[idx]) begin
          fails++;
          $display("FAIL wr_beat: got addr=%0d data=%h want addr=%0d data=%h",
                   mem_addr_o, mem_wdata_o, AW'(a + idx), d[idx]);
        end
      end
      if (vld && mrdy) idx++;
      @(posedge clk); #1;
      cyc++;
      if (cyc > CAP) begin
        fails++;
        $display("FAIL wr_timeout: got %0d beats want %0d", idx, n);
        break;
      end
    end
    wr_valid_i = 1'b0;
    mem_ready_i = 1'b1;
    if (mode == 0) begin
      checks++;
      if (cyc !== n) begin
        fails++;
        $display("FAIL wr_rate: got %0d cycles want %0d", cyc, n);
      end
    end
    @(negedge clk);
    checks++;
    if ({done_o, busy_o, mem_valid_o, wr_ready_o, cmd_ready_o}
        !== 5'b11000) begin
      fails++;
      $display("FAIL wr_done: got done=%b busy=%b v=%b rdy=%b cr=%b want 1 1 0 0 0",
               done_o, busy_o, mem_valid_o, wr_ready_o, cmd_ready_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({done_o, busy_o, cmd_ready_o, mem_addr_o} !== {3'b001, AW'(0)}) begin
      fails++;
      $display("FAIL wr_idle: got done=%b busy=%b cr=%b addr=%0d want 0 0 1 0",
               done_o, busy_o, cmd_ready_o, mem_addr_o);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mem[(a + i) % DEPTH] !== d[i]) begin
        fails++;
        $display("FAIL wr_mem: addr %0d got %h want %h",
                 (a + i) % DEPTH, mem[(a + i) % DEPTH], d[i]);
      end
      ref_mem[(a + i) % DEPTH] = d[i];
    end
  endtask

  task automatic run_read(input int a, input int n, input int mode);
    logic [WIDTH-1:0] exp_q [$];
    int issued;
    int popped;
    int avail;
    int cyc;
    bit last_beat;
    bit exp_mv;
    bit rdy;
    bit mrdy;
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(a + i) % DEPTH]);
    send_cmd(1'b0, a, n);
    issued = 0;
    popped = 0;
    cyc = 0;
    last_beat = 1'b0;
    while (popped < n) begin
      unique case (mode)
        0: begin rdy = 1'b1; mrdy = 1'b1; end
        1: begin rdy = (cyc % 4) == 0; mrdy = !(cyc == 3 || cyc == 4); end
        default: begin
          rdy = $urandom_range(2) != 0;
          mrdy = $urandom_range(3) != 0;
        end
      endcase
      rd_ready_i = rdy;
      mem_ready_i = mrdy;
      @(negedge clk);
      exp_mv = (issued < n) && (issued - popped < 2);
      avail = issued - int'(last_beat) - popped;
      checks++;
      if ({mem_valid_o, rd_valid_o, mem_w_r_o, busy_o, done_o}
          !== {exp_mv, avail > 0, 1'b0, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL rd_ctrl: got v=%b rv=%b w=%b busy=%b done=%b want %b %b 0 1 0",
                 mem_valid_o, rd_valid_o, mem_w_r_o, busy_o, done_o,
                 exp_mv, avail > 0);
      end
      if (exp_mv) begin
        checks++;
        if (mem_addr_o !== AW'(a + issued)) begin
          fails++;
          $display("FAIL rd_addr: got %0d want %0d",
                   mem_addr_o, AW'(a + issued));
        end
      end
      if (avail > 0) begin
        checks++;
        if (rd_data_o !== exp_q[popped]) begin
          fails++;
          $display("FAIL rd_data: word %0d got %h want %h",
                   popped, rd_data_o, exp_q[popped]);
        end
      end
      last_beat = exp_mv && mrdy;
      if (last_beat) issued++;
      if (avail > 0 && rdy) popped++;
      @(posedge clk); #1;
      cyc++;
      if (cyc > CAP) begin
        fails++;
        $display("FAIL rd_timeout: got %0d words want %0d", popped, n);
        break;
      end
    end
    rd_ready_i = 1'b1;
    mem_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({done_o, busy_o, mem_valid_o, rd_valid_o} !== 4'b0100) begin
      fails++;
      $display("FAIL rd_drain: got done=%b busy=%b v=%b rv=%b want 0 1 0 0",
               done_o, busy_o, mem_valid_o, rd_valid_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({done_o, busy_o, cmd_ready_o} !== 3'b110) begin
      fails++;
      $display("FAIL rd_done: got done=%b busy=%b cr=%b want 1 1 0",
               done_o, busy_o, cmd_ready_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({done_o, busy_o, cmd_ready_o} !== 3'b001) begin
      fails++;
      $display("FAIL rd_idle: got done=%b busy=%b cr=%b want 0 0 1",
               done_o, busy_o, cmd_ready_o);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_wr_i = 1'b1;
    cmd_addr_i = AW'(5);
    cmd_len_i = (AW+1)'(3);
    wr_valid_i = 1'b1;
    wr_data_i = 16'hBEEF;
    rd_ready_i = 1'b1;
    mem_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o, mem_valid_o,
         mem_w_r_o, mem_addr_o, mem_wdata_o, busy_o, done_o} !== '0) begin
      fails++;
      $display("FAIL reset_outs: got cr=%b wr=%b rv=%b v=%b busy=%b done=%b want all 0",
               cmd_ready_o, wr_ready_o, rd_valid_o, mem_valid_o,
               busy_o, done_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cmd_valid_i = 1'b0;
    wr_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got cr=%b want 0", cmd_ready_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({cmd_ready_o, busy_o} !== 2'b10) begin
      fails++;
      $display("FAIL reset_ready: got cr=%b busy=%b want 1 0",
               cmd_ready_o, busy_o);
    end
  endtask

  task automatic test_len_zero;
    wr_valid_i = 1'b1;
    mem_ready_i = 1'b1;
    send_cmd(1'($urandom), $urandom_range(DEPTH - 1), 0);
    @(negedge clk);
    checks++;
    if ({done_o, busy_o, mem_valid_o, cmd_ready_o} !== 4'b1100) begin
      fails++;
      $display("FAIL len0_done: got done=%b busy=%b v=%b cr=%b want 1 1 0 0",
               done_o, busy_o, mem_valid_o, cmd_ready_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({done_o, busy_o, mem_valid_o, cmd_ready_o} !== 4'b0001) begin
      fails++;
      $display("FAIL len0_idle: got done=%b busy=%b v=%b cr=%b want 0 0 0 1",
               done_o, busy_o, mem_valid_o, cmd_ready_o);
    end
    wr_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    logic [WIDTH-1:0] d [8];
    for (int i = 0; i < 8; i++) d[i] = WIDTH'($urandom);
    mem_ready_i = 1'b1;
    rd_ready_i = 1'b1;
    send_cmd(1'b1, 0, 8);
    for (int i = 0; i < 3; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i = d[i];
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o, mem_valid_o,
         mem_w_r_o, mem_addr_o, mem_wdata_o, busy_o, done_o} !== '0) begin
      fails++;
      $display("FAIL midrst_outs: got cr=%b wr=%b v=%b w=%b addr=%0d busy=%b want all 0",
               cmd_ready_o, wr_ready_o, mem_valid_o, mem_w_r_o,
               mem_addr_o, busy_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wr_valid_i = 1'b0;
    checks++;
    if (mem[2] !== ref_mem[2]) begin
      fails++;
      $display("FAIL midrst_nowrite: addr 2 got %h want %h",
               mem[2], ref_mem[2]);
    end
    ref_mem[0] = d[0];
    ref_mem[1] = d[1];
    run_read(0, 2, 0);
  endtask

  initial begin
    test_reset;
    run_write(0, 5, 0);
    run_read(0, 5, 0);
    run_write(14, 4, 0);
    run_read(14, 4, 0);
    run_write(3, 8, 2);
    run_read(3, 8, 1);
    test_len_zero;
    run_write(5, DEPTH, 2);
    run_read(5, DEPTH, 2);
    for (int k = 0; k < 6; k++) begin
      int a;
      int n;
      a = $urandom_range(DEPTH - 1);
      n = $urandom_range(DEPTH, 1);
      run_write(a, n, 2);
      run_read(a, n, 2);
    end
    test_reset_mid_burst;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
